uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer directly downstream of the UART receiver. It captures each byte the receiver completes on the rising edge of its `done` level and stores it in a first-word-fall-through FIFO. The stored bytes are presented to the host or bus side over a valid/ready handshake. The block also reports occupancy and latches a sticky overflow flag when a byte arrives while the FIFO is full.

## Interface
- `DEPTH`, 16: number of byte entries. Must be a power of two, minimum 2.
- `WIDTH`, 8: data width, matching the receiver's `data_out`.
- `rx_clk` in 1: single clock, the same clock that drives the UART receiver.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in WIDTH: byte from the receiver (`data_out`). Valid while `rx_done` is high.
- `rx_done` in 1: receiver completion level. It may stay high for several cycles per byte.
- `m_data` out WIDTH: head-of-FIFO byte, combinational from storage.
- `m_valid` out 1: FIFO not empty.
- `m_ready` in 1: consumer accepts `m_data` this cycle.
- `count` out $clog2(DEPTH)+1: current number of stored entries.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `overflow` out 1: sticky flag, set when a byte is dropped.
- `ovf_clr` in 1: synchronous clear of `overflow`.

## Operation
- **Capture:** register `done_d <= rx_done`. Define `wr_req = rx_done & ~done_d`. There is exactly one write request per receiver frame, no matter how long `rx_done` stays high.
- **Write:** on `wr_req`, `mem[wr_ptr] <= rx_data` and `wr_ptr` increments. This happens only if the FIFO is not full, or if it is full and a read occurs in the same cycle.
- **Read:** `rd_fire = m_valid & m_ready`. On `rd_fire`, `rd_ptr` increments. `m_data = mem[rd_ptr]`.
- **Pointers:** `log2(DEPTH)` bits each and wrap naturally. `count` is a separate register:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on simultaneous write and read.
- **Overflow:** if `wr_req` arrives while full and there is no same-cycle `rd_fire`, the byte is dropped and `overflow <= 1`. FIFO contents are unchanged.
- **Clearing overflow:** `ovf_clr` clears `overflow`. If `ovf_clr` and a drop occur in the same cycle, set wins.
- **Empty:**
  - `m_valid = 0`.
  - `m_ready` is ignored.
  - `m_data` is don't-care.
  - Write and read cannot coincide, because `m_valid = 0`.
- **No internal FSM beyond the edge detector.** Control state is `done_d`, `wr_ptr`, `rd_ptr`, `count`, `overflow`.

## Timing
- **Reset (`rst_n` low, asynchronous):**
  - `wr_ptr = rd_ptr = 0`, `count = 0`.
  - `empty = 1`, `full = 0`, `m_valid = 0`, `overflow = 0`.
  - `done_d = 1`, so an `rx_done` level held across reset release is not captured.
  - Storage contents are not reset. `m_data` is undefined until the first write.
- **Reset mid-operation:** all buffered bytes are discarded immediately. A partially observed `rx_done` pulse is ignored until `rx_done` falls and rises again.
- **Write latency:**
  - Edge E: `rx_done` rises (sampled high for the first time at E+1).
  - Edge E+1: the write occurs.
  - After E+1: `m_valid = 1` and `m_data` equals the byte.
  - Total: one cycle from the receiver asserting `done` to the byte being visible.
- **Read:** the handshake completes at the edge where `m_valid & m_ready` is sampled. The next entry, or `m_valid = 0`, appears after that edge. There are no bubbles; back-to-back reads proceed at one per cycle.
- **Full with simultaneous `wr_req` and `rd_fire`:** the write is accepted, `count` stays at DEPTH, and `overflow` is not set.
- **Status outputs:** `full`, `empty`, `count` are registered or derived from registered `count`, and update at the same edge as the pointer change.
- **Throughput:** one write per `rx_done` rising edge. The minimum gap between writes is 2 cycles (the edge detector requires `rx_done` to fall and rise again).

## Test plan
- **Single byte:** after reset, drive `rx_data = 0xA5` with `rx_done` high for 5 cycles, `m_ready = 0`. Expect exactly one entry: `count = 1`, `m_valid = 1`, `m_data = 0xA5` from the cycle after the first high sample. Then pulse `m_ready` for 1 cycle and expect `empty = 1`, `count = 0`.
- **Order and wrap:** write 0x00..0x0F (DEPTH = 16) with `m_ready = 0`. Expect `full = 1`, `count = 16`. Drain with `m_ready = 1` held and expect 0x00..0x0F in order on consecutive cycles. Repeat with 0x10..0x1F so both pointers wrap.
- **Overflow:** fill to full, then deliver 0xEE with `m_ready = 0`. Expect `overflow = 1`, `count = 16`, and 0xEE absent on drain. Assert `ovf_clr` and expect `overflow = 0` the next cycle. Assert `ovf_clr` in the same cycle as another drop and expect `overflow = 1`.
- **Full with simultaneous read and write:** at full, assert `m_ready` in the same cycle as the write edge of 0x77. Expect `count` to stay 16, `overflow = 0`, and 0x77 to be the last byte drained.
- **Reset mid-operation:** with 3 bytes stored and `rx_done` high, pulse `rst_n` low asynchronously, mid-cycle. Expect `count = 0`, `m_valid = 0`, `overflow = 0` immediately. No capture occurs until `rx_done` goes low and then high again, after which exactly one byte is stored.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through byte FIFO behind the UART receiver
// Captures one byte per rx_done rising edge and reports occupancy and sticky overflow.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     rx_clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_done,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             done_d;
  logic             wr_req;
  logic             rd_fire;
  logic             wr_en;
  logic             drop;

  assign wr_req  = rx_done & ~done_d;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign m_valid = ~empty;
  assign rd_fire = m_valid & m_ready;
  // A full FIFO still accepts the byte when the head leaves in the same cycle.
  assign wr_en   = wr_req & (~full | rd_fire);
  assign drop    = wr_req & full & ~rd_fire;
  assign m_data  = mem[rd_ptr];

  // done_d resets high so a done level held across reset release is not taken as an edge.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      done_d   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      done_d <= rx_done;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !rd_fire) begin
        count <= count + 1'b1;
      end else if (rd_fire && !wr_en) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge rx_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= rx_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
// Inputs change 1 ns after the rising edge; outputs are checked before the next edge.
module tb_uart_rx_fifo;

  logic       rx_clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       ovf_clr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .rx_clk   (rx_clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    m_ready = 1'b0;
    ovf_clr = 1'b0;
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single byte, done held for five cycles
    rx_data = 8'hA5;
    rx_done = 1'b1;
    tick();
    chk("single_count", 32'(count), 32'd1);
    chk("single_valid", 32'(m_valid), 32'd1);
    chk("single_data", 32'(m_data), 32'hA5);
    repeat (4) tick();
    chk("single_held_count", 32'(count), 32'd1);
    rx_done = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_count0", 32'(count), 32'd0);

    // order and wrap, two rounds
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) send(8'(r * 16 + i));
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd16);
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
        chk("drain_data", 32'(m_data), 32'(r * 16 + i));
        tick();
      end
      m_ready = 1'b0;
      chk("drain_empty", 32'(empty), 32'd1);
    end

    // overflow drop, clear, and set-wins-over-clear
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i));
    send(8'hEE);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    rx_data = 8'hEF;
    rx_done = 1'b1;
    ovf_clr = 1'b1;
    tick();
    rx_done = 1'b0;
    ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    tick();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", 32'(m_data), 32'(8'h20 + i));
      tick();
    end
    m_ready = 1'b0;
    chk("ovf_drain_empty", 32'(empty), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // full with simultaneous read and write
    for (int i = 0; i < 16; i++) send(8'(8'h30 + i));
    rx_data = 8'h77;
    rx_done = 1'b1;
    m_ready = 1'b1;
    tick();
    rx_done = 1'b0;
    m_ready = 1'b0;
    chk("rw_full_count", 32'(count), 32'd16);
    chk("rw_full_ovf", 32'(overflow), 32'd0);
    tick();
    m_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("rw_drain", 32'(m_data), 32'(8'h30 + i));
      tick();
    end
    chk("rw_last", 32'(m_data), 32'h77);
    tick();
    m_ready = 1'b0;
    chk("rw_empty", 32'(empty), 32'd1);

    // reset mid-operation with rx_done held high
    send(8'h01);
    send(8'h02);
    send(8'h03);
    chk("mid_pre_count", 32'(count), 32'd3);
    rx_data = 8'h55;
    rx_done = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("mid_held_count", 32'(count), 32'd0);
    rx_done = 1'b0;
    tick();
    rx_data = 8'h66;
    rx_done = 1'b1;
    tick();
    chk("mid_new_count", 32'(count), 32'd1);
    chk("mid_new_data", 32'(m_data), 32'h66);
    repeat (2) tick();
    chk("mid_one_only", 32'(count), 32'd1);
    rx_done = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
